// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier controller that drives an external
// combinational adder and accumulates a 2*WIDTH-bit product, one bit per clock.
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q_reg;
  logic [CW-1:0]    cnt;

  // One iteration: the adder's carry-out becomes the new MSB of acc, and the bit
  // shifted out of acc enters the top of q_reg, so nothing can overflow.
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] q_next;
  assign acc_next = {add_cout, add_sum[WIDTH-1:1]};
  assign q_next   = {add_sum[0], q_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      m_reg   <= '0;
      acc     <= '0;
      q_reg   <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc   <= acc_next;
          q_reg <= q_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            product <= {acc_next, q_next};
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Status and adder operands are decoded only from registered state; the adder
  // sees zeros whenever no iteration is in progress.
  assign busy    = (state == CALC);
  assign done    = (state == DONE);
  assign add_a   = (state == CALC) ? acc : '0;
  assign add_b   = ((state == CALC) && q_reg[0]) ? m_reg : '0;
  assign add_cin = 1'b0;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: stimulus pushes expected products,
// a monitor pops and compares on every done pulse, including latency and busy length.
module tb_shift_add_multiplier;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_cin;
  logic [W-1:0]   add_sum;
  logic           add_cout;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // External combinational adder
  assign {add_cout, add_sum} = add_a + add_b + add_cin;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*W-1:0] prod;
    int             accept;
    string          name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  bit   cout_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitor: compares whenever the DUT presents a done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (busy && add_cout) cout_seen = 1'b1;
        if (done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check({e.name, "_product"}, 32'(product), 32'(e.prod));
            check({e.name, "_latency"}, 32'(cyc - e.accept), 32'(W));
            check({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
            check({e.name, "_adder_idle"}, 32'({add_a, add_b}), 32'd0);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // mode 0: plain; 1: extra start pulse at CALC cycle 2; 2: reset at CALC cycle 2
  task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q,
                       input logic [2*W-1:0] exp_p, input string name, input int mode);
    exp_t e;
    bit   seen;
    int   dc;
    start        = 1'b1;
    multiplicand = m;
    multiplier   = q;
    @(posedge clk);
    #1;
    e.prod = exp_p; e.accept = cyc; e.name = name;
    exp_q.push_back(e);
    start = 1'b0;
    check({name, "_busy_rise"}, 32'(busy), 32'd1);
    check({name, "_first_add_a"}, 32'(add_a), 32'd0);
    check({name, "_first_add_b"}, 32'(add_b), q[0] ? 32'(m) : 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mode == 1 && i == 1) begin
        start = 1'b1; multiplicand = 4'd15; multiplier = 4'd15;
      end else if (mode == 1 && i == 2) begin
        start = 1'b0;
      end
      if (mode == 2 && i == 1) begin
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check({name, "_rst_busy"}, 32'(busy), 32'd0);
        check({name, "_rst_done"}, 32'(done), 32'd0);
        check({name, "_rst_product"}, 32'(product), 32'd0);
        check({name, "_rst_adder"}, 32'({add_a, add_b, add_cin}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dc = done_cnt;
        repeat (8) @(negedge clk);
        check({name, "_no_done_after_rst"}, 32'(done_cnt - dc), 32'd0);
        return;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check({name, "_done_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int dc;
    rst_n        = 1'b0;
    start        = 1'b1;
    multiplicand = 4'd5;
    multiplier   = 4'd10;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    check("reset_add_a", 32'(add_a), 32'd0);
    check("reset_add_b", 32'(add_b), 32'd0);
    check("reset_add_cin", 32'(add_cin), 32'd0);
    rst_n = 1'b1;

    dc = done_cnt;
    do_op(4'd5, 4'd10, 8'd50, "mul_5x10", 0);
    check("mul_5x10_done_once", 32'(done_cnt - dc), 32'd1);

    cout_seen = 1'b0;
    do_op(4'd15, 4'd15, 8'd225, "mul_15x15", 0);
    check("mul_15x15_cout_seen", 32'(cout_seen), 32'd1);

    do_op(4'd0, 4'd13, 8'd0, "mul_0x13", 0);
    do_op(4'd13, 4'd0, 8'd0, "mul_13x0", 0);

    dc = done_cnt;
    do_op(4'd3, 4'd7, 8'd21, "mul_3x7_poke", 1);
    check("mul_3x7_done_once", 32'(done_cnt - dc), 32'd1);

    do_op(4'd9, 4'd9, 8'd81, "mul_9x9_abort", 2);
    do_op(4'd9, 4'd9, 8'd81, "mul_9x9", 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential unsigned shift-and-add multiplier controller for the first CPU datapath. It produces two WIDTH-bit operands and a carry-in for the external combinational adder, then consumes that adder's sum and carry-out one iteration per clock. It accumulates a 2*WIDTH-bit product over WIDTH cycles and reports completion with a one-cycle done pulse. It is the stage directly upstream and downstream of the adder: every adder input comes from this block, and every adder result is registered here.

## Interface
- WIDTH, 4, operand width in bits; the product is 2*WIDTH bits; legal range is 2..16.
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- multiplicand  in  WIDTH  operand M; latched on accepted start.
- multiplier  in  WIDTH  operand Q; latched on accepted start.
- busy  out  1  high while in CALC.
- done  out  1  one-cycle pulse in DONE.
- product  out  2*WIDTH  result register; holds its value until the next completion.
- add_a  out  WIDTH  adder operand a.
- add_b  out  WIDTH  adder operand b.
- add_cin  out  1  adder carry-in; always 0.
- add_sum  in  WIDTH  adder sum, combinational from add_a, add_b and add_cin.
- add_cout  in  1  adder carry-out.

## Operation
- Registers:
  - m_reg (WIDTH): latched multiplicand.
  - acc (WIDTH): upper half of the running product.
  - q_reg (WIDTH): shifting multiplier and lower half of the product.
  - cnt: iteration counter, width clog2(WIDTH)+1.
  - state: one of IDLE, CALC, DONE.
- IDLE:
  - If start=1: m_reg<=multiplicand, q_reg<=multiplier, acc<=0, cnt<=0, next state CALC.
  - If start=0: stay in IDLE.
- CALC:
  - Adder drive: add_a=acc, add_b=(q_reg[0] ? m_reg : 0), add_cin=0.
  - At each edge: acc<={add_cout, add_sum[WIDTH-1:1]}, q_reg<={add_sum[0], q_reg[WIDTH-1:1]}, cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge: the iteration above still executes, product<={new acc, new q_reg}, next state DONE.
- DONE: done=1 for exactly one cycle, then unconditionally IDLE.
- Adder drive outside CALC: add_a=0, add_b=0, add_cin=0. This keeps adder activity deterministic.
- start is ignored in CALC and DONE; the operand inputs are not re-sampled there.
- A start held high through DONE is accepted on the first IDLE cycle that follows.
- Arithmetic: unsigned only. Carry-out is folded into acc on every shift, so no overflow is possible; the maximum result is (2^WIDTH-1)^2.
- Reset (asynchronous, any state including mid-CALC):
  - state=IDLE.
  - busy=0, done=0, product=0.
  - acc=0, q_reg=0, m_reg=0, cnt=0.
  - add_a=0, add_b=0, add_cin=0.
  - The in-flight operation is discarded, with no done pulse.

## Timing
- Edge E0 accepts start. Edges E0+1 .. E0+WIDTH perform the iterations. product is updated at E0+WIDTH. done is high during the cycle between E0+WIDTH and E0+WIDTH+1.
- For WIDTH=4, done is visible 4 cycles after the accepting edge.
- busy rises after E0 and falls after E0+WIDTH.
- Minimum start-to-start spacing is WIDTH+2 cycles.
- The adder path is purely combinational. add_sum and add_cout must settle within one clock after the registered add_a and add_b, and no handshake is applied to the adder.
- busy and done are decoded from registered state, so they are glitch-free.

## Test plan
- Reset: hold rst_n=0 with start=1 -> busy=0, done=0, product=0, add_a=0, add_b=0, add_cin=0. Release -> operation starts at the first edge.
- 5*10 (WIDTH=4) -> done pulses exactly once, 4 cycles after acceptance; product=8'd50. In the first CALC cycle add_b=0 because q_reg[0]=0.
- 15*15 -> product=8'd225 (8'hE1). add_cout=1 is observed in at least one iteration and is folded into acc.
- 0*13, then 13*0 -> product=0 in both cases; the latency is still 4 cycles.
- Pulse start again at cycle 2 of CALC while computing 3*7 -> the second pulse is ignored; product=21; busy stays high for exactly 4 cycles; done pulses exactly once.
- Reset mid-CALC during 9*9 -> immediate IDLE, no done pulse, product=0. A subsequent 9*9 completes with product=81.
